// File: rtl/alt_cal_seq.sv
// rtl/alt_cal_seq.sv - multi-channel transceiver offset-calibration sequencer
// Walks each channel, nudging a 4-bit offset code via DPRIO read-modify-write per comparator majority.
module alt_cal_seq #(
    parameter int          number_of_channels    = 1,
    parameter int          channel_address_width = 1,
    parameter logic [11:0] pma_base_address      = 12'h0,
    parameter logic [7:0]  sample_length         = 8'd100,
    parameter logic [3:0]  cal_steps             = 4'd8,
    parameter int          code_lsb              = 4,
    parameter logic [7:0]  timeout_cycles        = 8'd255
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [7:0]                    testbuses,
    input  logic [11:0]                   remap_addr,
    input  logic                          dprio_busy,
    input  logic [15:0]                   dprio_datain,
    output logic [15:0]                   dprio_addr,
    output logic [15:0]                   dprio_dataout,
    output logic                          dprio_rden,
    output logic                          dprio_wren,
    output logic [8:0]                    quad_addr,
    output logic                          busy,
    output logic [number_of_channels-1:0] done,
    output logic                          cal_error
);

    typedef enum logic [2:0] {IDLE, LOAD, RD_REQ, RD_WAIT, SAMPLE, WR_REQ, WR_WAIT, NEXT} state_t;

    localparam logic [channel_address_width-1:0] last_channel = channel_address_width'(number_of_channels - 1);
    localparam logic [number_of_channels-1:0]    chan_one     = number_of_channels'(1);

    state_t                           state, state_n;
    logic                             auto_run, auto_run_n;
    logic [channel_address_width-1:0] channel, channel_n;
    logic [3:0]                       step, step_n, step_inc;
    logic [7:0]                       sample_cnt, sample_cnt_n;
    logic [7:0]                       ones, ones_n, ones_total;
    logic [7:0]                       wait_cnt, wait_cnt_n;
    logic [15:0]                      data_reg, data_reg_n;
    logic [15:0]                      dprio_addr_n, dprio_dataout_n;
    logic                             rden_n, wren_n, cal_error_n, busy_n;
    logic [number_of_channels-1:0]    done_n;
    logic [3:0]                       code, code_n;
    logic                             timed_out, waiting;
    logic                             unused_testbuses;

    assign unused_testbuses = ^testbuses[7:1];

    always_comb begin
        state_n         = state;
        auto_run_n      = auto_run;
        channel_n       = channel;
        step_n          = step;
        sample_cnt_n    = sample_cnt;
        ones_n          = ones;
        data_reg_n      = data_reg;
        dprio_addr_n    = dprio_addr;
        dprio_dataout_n = dprio_dataout;
        rden_n          = 1'b0;
        wren_n          = 1'b0;
        done_n          = done;
        cal_error_n     = cal_error;
        code_n          = 4'd0;
        ones_total      = ones + {7'd0, testbuses[0]};
        code            = data_reg[code_lsb +: 4];
        step_inc        = step + 4'd1;
        timed_out       = (wait_cnt == timeout_cycles);

        case (state)
            IDLE: begin
                if (auto_run || start) begin
                    state_n     = LOAD;
                    auto_run_n  = 1'b0;
                    done_n      = '0;
                    cal_error_n = 1'b0;
                    channel_n   = '0;
                end
            end
            LOAD: begin
                dprio_addr_n = {4'b0, remap_addr + pma_base_address};
                step_n       = 4'd0;
                state_n      = RD_REQ;
            end
            RD_REQ: begin
                if (!dprio_busy) begin
                    rden_n  = 1'b1;
                    state_n = RD_WAIT;
                end else if (timed_out) begin
                    cal_error_n = 1'b1;
                    state_n     = NEXT;
                end
            end
            RD_WAIT: begin
                // wait_cnt==0 is the guard cycle right after the strobe
                if (wait_cnt != 8'd0 && !dprio_busy) begin
                    data_reg_n   = dprio_datain;
                    sample_cnt_n = 8'd0;
                    ones_n       = 8'd0;
                    state_n      = SAMPLE;
                end else if (timed_out) begin
                    cal_error_n = 1'b1;
                    state_n     = NEXT;
                end
            end
            SAMPLE: begin
                ones_n       = ones_total;
                sample_cnt_n = sample_cnt + 8'd1;
                if (sample_cnt == sample_length - 8'd1) begin
                    if ({ones_total, 1'b0} > {1'b0, sample_length})
                        code_n = (code == 4'd0) ? 4'd0 : code - 4'd1;
                    else
                        code_n = (code == 4'd15) ? 4'd15 : code + 4'd1;
                    data_reg_n[code_lsb +: 4] = code_n;
                    state_n = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!dprio_busy) begin
                    wren_n          = 1'b1;
                    dprio_dataout_n = data_reg;
                    state_n         = WR_WAIT;
                end else if (timed_out) begin
                    cal_error_n = 1'b1;
                    state_n     = NEXT;
                end
            end
            WR_WAIT: begin
                if (wait_cnt != 8'd0 && !dprio_busy) begin
                    step_n = step_inc;
                    if (step_inc < cal_steps) begin
                        state_n = RD_REQ;
                    end else begin
                        // flagged on entry so done is visible during NEXT
                        done_n  = done | (chan_one << channel);
                        state_n = NEXT;
                    end
                end else if (timed_out) begin
                    cal_error_n = 1'b1;
                    state_n     = NEXT;
                end
            end
            NEXT: begin
                if (channel == last_channel) begin
                    state_n = IDLE;
                end else begin
                    channel_n = channel + 1'b1;
                    state_n   = LOAD;
                end
            end
            default: state_n = IDLE;
        endcase

        waiting    = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ) || (state == WR_WAIT);
        wait_cnt_n = (waiting && state_n == state) ? wait_cnt + 8'd1 : 8'd0;
        busy_n     = (state_n != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            auto_run      <= 1'b1;
            channel       <= '0;
            step          <= 4'd0;
            sample_cnt    <= 8'd0;
            ones          <= 8'd0;
            wait_cnt      <= 8'd0;
            data_reg      <= 16'd0;
            dprio_addr    <= 16'd0;
            dprio_dataout <= 16'd0;
            dprio_rden    <= 1'b0;
            dprio_wren    <= 1'b0;
            quad_addr     <= 9'd0;
            busy          <= 1'b0;
            done          <= '0;
            cal_error     <= 1'b0;
        end else begin
            state         <= state_n;
            auto_run      <= auto_run_n;
            channel       <= channel_n;
            step          <= step_n;
            sample_cnt    <= sample_cnt_n;
            ones          <= ones_n;
            wait_cnt      <= wait_cnt_n;
            data_reg      <= data_reg_n;
            dprio_addr    <= dprio_addr_n;
            dprio_dataout <= dprio_dataout_n;
            dprio_rden    <= rden_n;
            dprio_wren    <= wren_n;
            quad_addr     <= 9'(channel_n);
            busy          <= busy_n;
            done          <= done_n;
            cal_error     <= cal_error_n;
        end
    end

endmodule

// File: tb/tb_alt_cal_seq.sv
// tb/tb_alt_cal_seq.sv - bench for alt_cal_seq with a DPRIO slave model and transaction scoreboard
module tb_alt_cal_seq;

    localparam int SL = 4;
    localparam int CS = 2;
    localparam int TO = 30;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    logic        clock = 1'b0;
    logic        reset_a, reset_b, start;
    logic [7:0]  testbuses;
    logic [11:0] remap_addr;
    logic        dprio_busy;
    logic [15:0] dprio_datain;

    logic [15:0] addr_a, addr_b, dout_a, dout_b;
    logic        rden_a, rden_b, wren_a, wren_b, busy_a, busy_b, err_a, err_b;
    logic [8:0]  quad_a, quad_b;
    logic [0:0]  done_a;
    logic [3:0]  done_b;

    logic        rden, wren, busy_any;
    logic [15:0] addr, dout;
    logic [8:0]  quad;
    logic [3:0]  done_any;

    int          checks = 0;
    int          errors = 0;
    int          stall_len = 0;
    int          stall_cnt = 0;
    bit          stuck = 1'b0;
    logic [15:0] init_val;
    logic [15:0] mem [int];
    txn_t        exp_q[$];
    logic [3:0]  prev_done = 4'd0;

    always #5 clock = ~clock;

    // inactive instance is held in reset so its outputs are all 0 and can be OR-merged
    assign rden       = rden_a | rden_b;
    assign wren       = wren_a | wren_b;
    assign busy_any   = busy_a | busy_b;
    assign addr       = addr_a | addr_b;
    assign dout       = dout_a | dout_b;
    assign quad       = quad_a | quad_b;
    assign done_any   = {3'b0, done_a} | done_b;
    assign remap_addr = (12'(quad) + 12'd1) << 8;

    alt_cal_seq #(.number_of_channels(1), .channel_address_width(1), .pma_base_address(12'h020),
                  .sample_length(8'(SL)), .cal_steps(4'(CS)), .code_lsb(4), .timeout_cycles(8'(TO))) u_a (
        .clock(clock), .reset(reset_a), .start(start), .testbuses(testbuses), .remap_addr(remap_addr),
        .dprio_busy(dprio_busy), .dprio_datain(dprio_datain), .dprio_addr(addr_a), .dprio_dataout(dout_a),
        .dprio_rden(rden_a), .dprio_wren(wren_a), .quad_addr(quad_a), .busy(busy_a), .done(done_a),
        .cal_error(err_a));

    alt_cal_seq #(.number_of_channels(4), .channel_address_width(2), .pma_base_address(12'h020),
                  .sample_length(8'(SL)), .cal_steps(4'(CS)), .code_lsb(4), .timeout_cycles(8'(TO))) u_b (
        .clock(clock), .reset(reset_b), .start(start), .testbuses(testbuses), .remap_addr(remap_addr),
        .dprio_busy(dprio_busy), .dprio_datain(dprio_datain), .dprio_addr(addr_b), .dprio_dataout(dout_b),
        .dprio_rden(rden_b), .dprio_wren(wren_b), .quad_addr(quad_b), .busy(busy_b), .done(done_b),
        .cal_error(err_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected DPRIO traffic from the calibration rules: per channel, CS read/write pairs
    task automatic build_expect(input int nch, input int skip);
        txn_t        t;
        logic [15:0] d;
        int          code, ones;
        exp_q.delete();
        mem.delete();
        for (int ch = 0; ch < nch; ch++) begin
            if (ch == skip) continue;
            d = init_val;
            for (int s = 0; s < CS; s++) begin
                t.wr   = 1'b0;
                t.addr = 16'(((ch + 1) * 256 + 32) % 4096);
                t.data = 16'h0;
                exp_q.push_back(t);
                code = int'((d >> 4) & 16'hF);
                ones = testbuses[0] ? SL : 0;
                if (2 * ones > SL) code = (code == 0) ? 0 : code - 1;
                else               code = (code == 15) ? 15 : code + 1;
                d = (d & 16'hFF0F) | 16'(code << 4);
                t.wr   = 1'b1;
                t.data = d;
                exp_q.push_back(t);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic wait_pass(input int poke, output int len);
        int n;
        n   = 0;
        len = 0;
        while (!busy_any && n < 200) begin @(negedge clock); n++; end
        check("pass_started", busy_any, 1);
        while (busy_any && len < 5000) begin
            start = (len == poke);
            len++;
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    // DPRIO slave + scoreboard: compare every strobe, then update slave state
    always @(negedge clock) begin
        txn_t t;
        logic [3:0] nb;
        if (rden || wren) begin
            check("strobe_excl", 32'(rden & wren), 0);
            check("strobe_while_busy", 32'(dprio_busy), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                t = exp_q.pop_front();
                check("txn_kind", 32'(wren), 32'(t.wr));
                check("txn_addr", 32'(addr), 32'(t.addr));
                if (t.wr) check("txn_data", 32'(dout), 32'(t.data));
            end
            if (wren) mem[int'(addr)] = dout;
            stall_cnt = (stall_len > 0) ? stall_len + 1 : 0;
        end else if (stall_cnt > 0) begin
            stall_cnt--;
        end
        dprio_busy   = (stall_cnt > 0) || (stuck && busy_b && quad_b == 9'd1);
        dprio_datain = mem.exists(int'(addr)) ? mem[int'(addr)] : init_val;
        if (done_any != prev_done && done_any != 4'd0) begin
            nb = done_any ^ prev_done;
            check("done_fill", 32'(((done_any & prev_done) == prev_done) && $onehot(nb) && (nb > prev_done)), 1);
        end
        prev_done = done_any;
    end

    initial begin
        int len;
        int n;
        reset_a = 1'b1; reset_b = 1'b1; start = 1'b0; testbuses = 8'd0; init_val = 16'h0000;
        dprio_busy = 1'b0; dprio_datain = 16'h0;
        repeat (3) @(negedge clock);
        check("rst_rden", 32'(rden), 0);
        check("rst_wren", 32'(wren), 0);
        check("rst_busy", 32'(busy_any), 0);
        check("rst_done", 32'(done_any), 0);
        check("rst_err", 32'(err_a | err_b), 0);
        check("rst_quad", 32'(quad), 0);
        check("rst_addr", 32'(addr), 0);

        // power-up auto pass, one channel, code 0 -> 1 -> 2
        build_expect(1, -1);
        check("model_pu_w0", 32'(exp_q[1].data), 32'h0010);
        check("model_pu_w1", 32'(exp_q[3].data), 32'h0020);
        reset_a = 1'b0;
        wait_pass(-1, len);
        check("pu_len", len, 22);
        check("pu_done", 32'(done_a), 1);
        check("pu_err", 32'(err_a), 0);
        check("pu_drained", exp_q.size(), 0);
        check("pu_mem", 32'(mem[32'h120]), 32'h0020);
        repeat (3) @(negedge clock);
        check("pu_no_rerun", 32'(busy_any), 0);

        // saturating decrement, bits outside [7:4] untouched
        testbuses = 8'd1; init_val = 16'hFFFF;
        build_expect(1, -1);
        check("model_sat_w0", 32'(exp_q[1].data), 32'hFFEF);
        check("model_sat_w1", 32'(exp_q[3].data), 32'hFFDF);
        pulse_start();
        wait_pass(-1, len);
        check("sat_len", len, 22);
        check("sat_mem", 32'(mem[32'h120]), 32'hFFDF);
        check("sat_drained", exp_q.size(), 0);

        // 10-cycle stall after each of the 4 strobes
        testbuses = 8'd0; init_val = 16'h0000; stall_len = 10;
        build_expect(1, -1);
        pulse_start();
        wait_pass(-1, len);
        check("stall_len", len, 22 + 4 * 10);
        check("stall_done", 32'(done_a), 1);
        check("stall_drained", exp_q.size(), 0);
        stall_len = 0;

        // start mid-pass is dropped
        build_expect(1, -1);
        pulse_start();
        wait_pass(5, len);
        check("midstart_len", len, 22);
        repeat (4) @(negedge clock);
        check("midstart_no_requeue", 32'(busy_any), 0);
        check("midstart_drained", exp_q.size(), 0);

        // reset during a write strobe
        build_expect(1, -1);
        pulse_start();
        n = 0;
        while (!wren_a && n < 200) begin @(negedge clock); n++; end
        check("rstw_seen", 32'(wren_a), 1);
        reset_a = 1'b1;
        @(negedge clock);
        check("rstw_wren", 32'(wren_a), 0);
        check("rstw_busy", 32'(busy_a), 0);
        check("rstw_done", 32'(done_a), 0);
        check("rstw_addr", 32'(addr_a), 0);
        check("rstw_dout", 32'(dout_a), 0);
        build_expect(1, -1);
        reset_a = 1'b0;
        wait_pass(-1, len);
        check("rstw_len", len, 22);
        check("rstw_done2", 32'(done_a), 1);
        check("rstw_drained", exp_q.size(), 0);

        // four channels through the remap block
        reset_a = 1'b1;
        @(negedge clock);
        build_expect(4, -1);
        check("model_ad0", 32'(exp_q[0].addr), 32'h0120);
        check("model_ad1", 32'(exp_q[4].addr), 32'h0220);
        check("model_ad2", 32'(exp_q[8].addr), 32'h0320);
        check("model_ad3", 32'(exp_q[12].addr), 32'h0420);
        reset_b = 1'b0;
        wait_pass(-1, len);
        check("mc_len", len, 4 * 22);
        check("mc_done", 32'(done_b), 32'hF);
        check("mc_err", 32'(err_b), 0);
        check("mc_drained", exp_q.size(), 0);

        // channel 1 never sees dprio_busy drop
        stuck = 1'b1;
        build_expect(4, 1);
        pulse_start();
        wait_pass(-1, len);
        check("to_len_range", 32'(len >= 3 * 22 + TO + 2 && len <= 3 * 22 + TO + 3), 1);
        check("to_err", 32'(err_b), 1);
        check("to_done", 32'(done_b), 32'hD);
        check("to_drained", exp_q.size(), 0);
        stuck = 1'b0;

        // next pass clears the sticky error
        build_expect(4, -1);
        pulse_start();
        wait_pass(-1, len);
        check("rec_len", len, 4 * 22);
        check("rec_err", 32'(err_b), 0);
        check("rec_done", 32'(done_b), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
